// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
// Instruction fetch controller between the PC register / decode stage and a
// sram-like instruction bus. It issues one read at a time. It can kill an
// in-flight read on flush. It holds the fetched instruction for decode until
// decode accepts it.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pc_i            PC to fetch
//   fetch_en        pipeline requests a fetch of pc_i
//   flush           kill any in-flight fetch
//   id_stall        decode cannot accept an instruction this cycle
//   inst_req/wr/size/addr/wdata   sram-like request side (read-only use)
//   inst_addr_ok, inst_data_ok, inst_rdata   sram-like response side
//   inst_o, inst_pc_o, inst_valid_o, addr_err_o   instruction to decode
//   if_stall        hold the PC register while high
module inst_fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic        id_stall,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        addr_err_o,
  output logic        if_stall
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DISCARD = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        kill_r, kill_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] inst_r, inst_s;
  logic [31:0] pc_r, pc_s;
  logic        err_r, err_s;
  logic        if_stall_s;

  // State and holding registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      kill_r  <= 1'b0;
      addr_r  <= 32'h0000_0000;
      inst_r  <= 32'h0000_0000;
      pc_r    <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      kill_r  <= kill_s;
      addr_r  <= addr_s;
      inst_r  <= inst_s;
      pc_r    <= pc_s;
      err_r   <= err_s;
    end
  end

  // Next-state, data capture and PC stall decode.
  always_comb begin
    state_s    = state_r;
    kill_s     = kill_r;
    addr_s     = addr_r;
    inst_s     = inst_r;
    pc_s       = pc_r;
    err_s      = err_r;
    if_stall_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fetch_en && !flush) begin
          if_stall_s = 1'b1;
          if (pc_i[1:0] == 2'b00) begin
            addr_s  = pc_i;
            state_s = ST_REQ;
          end else begin
            // Misaligned: report the error to decode without touching the bus.
            inst_s  = 32'h0000_0000;
            pc_s    = pc_i;
            err_s   = 1'b1;
            state_s = ST_HOLD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if_stall_s = 1'b1;
        // The request cannot be withdrawn. A flush seen before the address is
        // accepted is remembered so the returning data gets dropped.
        if (inst_addr_ok) begin
          kill_s  = 1'b0;
          state_s = (flush || kill_r) ? ST_DISCARD : ST_WAIT;
        end else if (flush) begin
          kill_s = 1'b1;
        end else begin
          kill_s = kill_r;
        end
      end
      ST_WAIT: begin
        if_stall_s = 1'b1;
        if (inst_data_ok) begin
          if (flush) begin
            state_s = ST_IDLE;
          end else begin
            inst_s  = inst_rdata;
            pc_s    = addr_r;
            err_s   = 1'b0;
            state_s = ST_HOLD;
          end
        end else if (flush) begin
          state_s = ST_DISCARD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DISCARD: begin
        if_stall_s = 1'b1;
        if (inst_data_ok) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DISCARD;
        end
      end
      ST_HOLD: begin
        if (id_stall && !flush) begin
          if_stall_s = 1'b1;
          state_s    = ST_HOLD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        kill_s  = 1'b0;
      end
    endcase
  end

  assign inst_req     = (state_r == ST_REQ);
  assign inst_wr      = 1'b0;
  assign inst_size    = 2'b10;
  assign inst_addr    = addr_r;
  assign inst_wdata   = 32'h0000_0000;
  assign inst_o       = inst_r;
  assign inst_pc_o    = pc_r;
  assign inst_valid_o = (state_r == ST_HOLD);
  assign addr_err_o   = err_r;
  // The IDLE term depends on fetch_en, so reset masks it explicitly.
  assign if_stall     = if_stall_s & ~rst;

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, asynchronous, active-high; clears all state immediately.
REQ-003 pc_i  in  32  current PC from the PC register.
REQ-004 fetch_en  in  1  pipeline requests a fetch of pc_i.
REQ-005 flush  in  1  kill any in-flight fetch (exception/branch redirect).
REQ-006 id_stall  in  1  decode stage cannot accept an instruction this cycle.
REQ-007 inst_req  out  1  sram-like request.
REQ-008 inst_wr  out  1  constant 0.
REQ-009 inst_size  out  2  constant 2'b10.
REQ-010 inst_addr  out  32  request address.
REQ-011 inst_wdata  out  32  constant 0.
REQ-012 inst_addr_ok  in  1  address accepted.
REQ-013 inst_data_ok  in  1  read data returned.
REQ-014 inst_rdata  in  32  read data.
REQ-015 inst_o  out  32  fetched instruction.
REQ-016 inst_pc_o  out  32  PC of inst_o.
REQ-017 inst_valid_o  out  1  inst_o/inst_pc_o valid to decode.
REQ-018 addr_err_o  out  1  misaligned fetch; qualified by inst_valid_o.
REQ-019 if_stall  out  1  hold PC register; PC advances only when low.

Function
REQ-020 States SHALL be IDLE, REQ, WAIT, DISCARD, HOLD; all are registered.
REQ-021 IDLE, fetch_en=1, flush=0, pc_i[1:0]=0: latch pc_i into addr_q, go to REQ.
REQ-022 IDLE, fetch_en=1, flush=0, pc_i[1:0]!=0: no bus request; latch inst_o=0, inst_pc_o=pc_i, addr_err_o=1; go to HOLD.
REQ-023 IDLE, flush=1: stay in IDLE regardless of fetch_en.
REQ-024 REQ: inst_req=1, inst_addr=addr_q; req held until inst_addr_ok, even under flush.
REQ-025 REQ, addr_ok=1: go to WAIT, or to DISCARD if flush is high this cycle or was seen earlier in REQ (sticky kill flag).
REQ-026 inst_req SHALL be 0 in every state except REQ; inst_addr=addr_q at all times.
REQ-027 WAIT, data_ok=1, flush=0: latch inst_o=inst_rdata, inst_pc_o=addr_q, addr_err_o=0; go to HOLD.
REQ-028 WAIT, flush=1 without data_ok: go to DISCARD.
REQ-029 WAIT, data_ok=1 and flush=1 in the same cycle: drop data, go to IDLE.
REQ-030 DISCARD: wait for data_ok, drop data, go to IDLE; flush is ignored.
REQ-031 inst_data_ok SHALL be ignored in IDLE, REQ and HOLD.
REQ-032 inst_valid_o SHALL be 1 exactly when state is HOLD.
REQ-033 HOLD, id_stall=0 or flush=1: go to IDLE; inst_o/inst_pc_o hold their values.
REQ-034 HOLD, id_stall=1, flush=0: remain in HOLD; outputs stable.
REQ-035 if_stall SHALL be 1 in REQ, WAIT and DISCARD.
REQ-036 if_stall SHALL be 1 in IDLE when fetch_en=1 and flush=0.
REQ-037 if_stall SHALL be 1 in HOLD when id_stall=1 and flush=0.
REQ-038 if_stall SHALL be 0 in all other cases.
REQ-039 Latency: data_ok in cycle N gives inst_valid_o in cycle N+1; at most one outstanding transaction.

Reset
REQ-040 Reset SHALL force state=IDLE and clear the kill flag.
REQ-041 Reset SHALL clear addr_q, inst_req, inst_o, inst_pc_o, inst_valid_o, addr_err_o and if_stall to 0.
REQ-042 Reset mid-transaction SHALL abandon it; a late data_ok after reset is ignored (state IDLE).

Verification
REQ-043 pc_i=0xBFC00000, fetch_en=1, addr_ok after 2 cycles, data_ok=0x24080001 after 3 more -> inst_valid_o=1 one cycle later, inst_o=0x24080001, inst_pc_o=0xBFC00000, if_stall low that cycle.
REQ-044 same fetch with id_stall=1 for 4 cycles after data -> inst_valid_o high for 5 cycles, outputs constant, if_stall high until id_stall drops.
REQ-045 flush in WAIT before data_ok=0xDEADBEEF -> DISCARD, no inst_valid_o, next fetch of 0xBFC00004 returns its own data.
REQ-046 flush asserted in REQ, addr_ok 2 cycles later -> inst_req stays high until addr_ok, then DISCARD; data_ok dropped.
REQ-047 pc_i=0xBFC00002, fetch_en=1 -> inst_req never asserted, next cycle inst_valid_o=1, addr_err_o=1, inst_o=0, inst_pc_o=0xBFC00002.
REQ-048 rst pulse while in WAIT, then data_ok -> all outputs 0, state IDLE, no inst_valid_o.
